// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Central stall / forward / flush controller for the five-stage MIPS pipeline.
// Decode-stage source registers are compared against the result class (Res)
// and destination register carried by the E, M and W pipeline registers.
// The block produces the PC / IF-ID write enables, the bubble and flush
// controls of the IF-ID, ID-EX and EX-MEM registers, and every forwarding
// mux select. It also owns the multiply/divide busy counter and the
// exception-flush sequencing, so the pipeline registers carry no hazard logic.
//
// Parameters
//   MULT_CYC    busy cycles after a mult/multu start
//   DIV_CYC     busy cycles after a div/divu start
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous active-low reset
//   rs_D, rt_D               decode-stage source registers
//   tuse_rs_D, tuse_rt_D     cycles until D needs the operand, 3 = unused
//   md_use_D                 D instruction touches the mult/div unit
//   wa_E, wa_M, wa_W         destination register of each later stage
//   Res_E, Res_M, Res_W      result class (0 NW, 1 ALU, 2 DM, 3 PC, 4 MD,
//                            5..7 behave as NW)
//   rs_E, rt_E, rt_M         operand registers of the E and M stages
//   md_start_E               mult/div issuing from E this cycle
//   md_div_E                 1 = divide, 0 = multiply (with md_start_E)
//   exc_req                  CP0 exception / interrupt taken at M
//   en_PC, en_D              PC and IF-ID write enables
//   flush_D, flush_E,        synchronous clear of IF-ID, ID-EX, EX-MEM
//   flush_M                  on the next edge
//   md_busy                  mult/div unit busy
//   fwd_rs_D, fwd_rt_D       0 regfile, 1 E, 2 M, 3 W
//   fwd_rs_E, fwd_rt_E       0 pipeline value, 2 M, 3 W
//   fwd_rt_M                 0 pipeline value, 1 W
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic       md_use_D,
  input  logic [4:0] wa_E,
  input  logic [4:0] wa_M,
  input  logic [4:0] wa_W,
  input  logic [2:0] Res_E,
  input  logic [2:0] Res_M,
  input  logic [2:0] Res_W,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] rt_M,
  input  logic       md_start_E,
  input  logic       md_div_E,
  input  logic       exc_req,
  output logic       en_PC,
  output logic       en_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       md_busy,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       fwd_rt_M
);

  // ---------------------------------------------------------------------------
  // Result classes and the busy counter width (sized for max(MULT_CYC, DIV_CYC))
  // ---------------------------------------------------------------------------
  localparam logic [2:0] RES_NW  = 3'd0;
  localparam logic [2:0] RES_ALU = 3'd1;
  localparam logic [2:0] RES_DM  = 3'd2;
  localparam logic [2:0] RES_PC  = 3'd3;
  localparam logic [2:0] RES_MD  = 3'd4;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Classes 1..4 write the register file; 0 and 5..7 do not.
  function automatic logic is_wr(input logic [2:0] res);
    return (res >= RES_ALU) && (res <= RES_MD);
  endfunction

  // Cycles until a result sitting in E is available for forwarding.
  function automatic logic [1:0] tnew_at_e(input logic [2:0] res);
    logic [1:0] t;
    case (res)
      RES_ALU: t = 2'd1;
      RES_DM:  t = 2'd2;
      RES_MD:  t = 2'd1;
      default: t = 2'd0;   // PC (link) is ready in E; NW never matches
    endcase
    return t;
  endfunction

  // In M only a load is still outstanding.
  function automatic logic [1:0] tnew_at_m(input logic [2:0] res);
    return (res == RES_DM) ? 2'd1 : 2'd0;
  endfunction

  // A stage produces the register src when it writes and targets it; r0 is
  // hard-wired so a zero destination never creates a dependency.
  function automatic logic hit(input logic [4:0] wa,
                               input logic [2:0] res,
                               input logic [4:0] src);
    return is_wr(res) && (wa != 5'd0) && (wa == src);
  endfunction

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] busy_cnt;

  logic [1:0] tnew_E, tnew_M;
  logic       rs_hit_E, rs_hit_M, rs_hit_W;
  logic       rt_hit_E, rt_hit_M, rt_hit_W;
  logic       stall_rs, stall_rt, stall_md, stall;
  logic       ready_E, ready_M;

  assign tnew_E = tnew_at_e(Res_E);
  assign tnew_M = tnew_at_m(Res_M);

  // Only stages whose result already exists may feed a forwarding mux.
  assign ready_E = (tnew_E == 2'd0);
  assign ready_M = (tnew_M == 2'd0);

  assign rs_hit_E = hit(wa_E, Res_E, rs_D);
  assign rs_hit_M = hit(wa_M, Res_M, rs_D);
  assign rs_hit_W = hit(wa_W, Res_W, rs_D);
  assign rt_hit_E = hit(wa_E, Res_E, rt_D);
  assign rt_hit_M = hit(wa_M, Res_M, rt_D);
  assign rt_hit_W = hit(wa_W, Res_W, rt_D);

  // ---------------------------------------------------------------------------
  // Stall detection
  // A D operand must wait while a producer in E or M will not have its value
  // by the time D needs it (Tnew > Tuse). W is always ready, so it never stalls.
  // ---------------------------------------------------------------------------
  assign stall_rs = (tuse_rs_D != TUSE_NONE) &&
                    ((rs_hit_E && (tnew_E > tuse_rs_D)) ||
                     (rs_hit_M && (tnew_M > tuse_rs_D)));

  assign stall_rt = (tuse_rt_D != TUSE_NONE) &&
                    ((rt_hit_E && (tnew_E > tuse_rt_D)) ||
                     (rt_hit_M && (tnew_M > tuse_rt_D)));

  // The mult/div unit is single-issue: anything touching HI/LO waits while an
  // operation is starting or still counting.
  assign stall_md = md_use_D && (md_start_E || md_busy);

  assign stall = stall_rs || stall_rt || stall_md;

  // ---------------------------------------------------------------------------
  // Forwarding selects (nearest ready producer wins)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    fwd_rs_D = 2'd0;
    if (rs_hit_E && ready_E)      fwd_rs_D = 2'd1;
    else if (rs_hit_M && ready_M) fwd_rs_D = 2'd2;
    else if (rs_hit_W)            fwd_rs_D = 2'd3;

    fwd_rt_D = 2'd0;
    if (rt_hit_E && ready_E)      fwd_rt_D = 2'd1;
    else if (rt_hit_M && ready_M) fwd_rt_D = 2'd2;
    else if (rt_hit_W)            fwd_rt_D = 2'd3;

    fwd_rs_E = 2'd0;
    if (hit(wa_M, Res_M, rs_E) && ready_M) fwd_rs_E = 2'd2;
    else if (hit(wa_W, Res_W, rs_E))       fwd_rs_E = 2'd3;

    fwd_rt_E = 2'd0;
    if (hit(wa_M, Res_M, rt_E) && ready_M) fwd_rt_E = 2'd2;
    else if (hit(wa_W, Res_W, rt_E))       fwd_rt_E = 2'd3;

    fwd_rt_M = hit(wa_W, Res_W, rt_M);
  end

  // ---------------------------------------------------------------------------
  // Mult/div busy counter
  // A start taken in the same cycle as an exception belongs to a squashed
  // instruction and is ignored; an operation already counting runs to the end.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!reset) begin
      busy_cnt <= '0;
    end else if (md_start_E && !exc_req) begin
      busy_cnt <= md_div_E ? DIV_LOAD : MULT_LOAD;
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - 1'b1;
    end
  end

  assign md_busy = (busy_cnt != '0);

  // ---------------------------------------------------------------------------
  // Exception sequencing FSM
  // EXC marks the cycle after an exception: the instruction fetched in that
  // slot is the delay-slot successor and must be discarded from IF-ID.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Both states react identically to a new request, so EXC re-arms itself
  // when exceptions arrive back to back.
  always_comb begin
    state_nxt = ST_RUN;
    case (state)
      ST_RUN:  state_nxt = exc_req ? ST_EXC : ST_RUN;
      ST_EXC:  state_nxt = exc_req ? ST_EXC : ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Exception flushing overrides any stall: the pipeline must redirect to the
  // handler. Otherwise a stall freezes PC and IF-ID and injects a bubble into
  // ID-EX. The EXC discard of IF-ID is kept even when D also stalls, because
  // the slot being held is the squashed fetch.
  always_comb begin
    en_PC   = 1'b1;
    en_D    = 1'b1;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_M = 1'b0;
    if (exc_req) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_M = 1'b1;
    end else begin
      en_PC   = !stall;
      en_D    = !stall;
      flush_E = stall;
      flush_D = (state == ST_EXC);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rs_D, rt_D, wa_E, wa_M, wa_W, rs_E, rt_E, rt_M;
  logic [1:0] tuse_rs_D, tuse_rt_D;
  logic [2:0] Res_E, Res_M, Res_W;
  logic       md_use_D, md_start_E, md_div_E, exc_req;
  logic       en_PC, en_D, flush_D, flush_E, flush_M, md_busy, fwd_rt_M;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_use_D(md_use_D), .wa_E(wa_E), .wa_M(wa_M), .wa_W(wa_W),
    .Res_E(Res_E), .Res_M(Res_M), .Res_W(Res_W),
    .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .exc_req(exc_req),
    .en_PC(en_PC), .en_D(en_D), .flush_D(flush_D), .flush_E(flush_E),
    .flush_M(flush_M), .md_busy(md_busy),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
    .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
  );

  // {en_PC, en_D, flush_D, flush_E, flush_M, md_busy, fwd_rs_D, fwd_rt_D,
  //  fwd_rs_E, fwd_rt_E, fwd_rt_M}
  logic [14:0] act;
  assign act = {en_PC, en_D, flush_D, flush_E, flush_M, md_busy,
                fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M};

  function automatic logic [14:0] pack(input logic epc, input logic ed,
      input logic fd, input logic fe, input logic fm, input logic busy,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
      input logic [1:0] d, input logic e);
    return {epc, ed, fd, fe, fm, busy, a, b, c, d, e};
  endfunction

  task automatic check(input string name, input logic [14:0] got,
                       input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic neutral();
    rs_D = 0; rt_D = 0; tuse_rs_D = 3; tuse_rt_D = 3; md_use_D = 0;
    wa_E = 0; wa_M = 0; wa_W = 0; Res_E = 0; Res_M = 0; Res_W = 0;
    rs_E = 0; rt_E = 0; rt_M = 0; md_start_E = 0; md_div_E = 0; exc_req = 0;
  endtask

  // Outputs of an idle pipeline: enables high, no flushes, no forwarding.
  localparam logic [14:0] IDLE = 15'b110000_00_00_00_00_0;
  // A plain stall: enables low, bubble into E.
  localparam logic [14:0] STALL = 15'b000100_00_00_00_00_0;

  // ---------------------------------------------------------------------------
  // Directed single-cycle vectors (RUN state, counter idle)
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [4:0] rs_d, rt_d;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] wa_e; logic [2:0] res_e;
    logic [4:0] wa_m; logic [2:0] res_m;
    logic [4:0] wa_w; logic [2:0] res_w;
    logic [4:0] rs_e, rt_e, rt_m;
    logic       x_stall;
    logic [1:0] x_rs_d, x_rt_d, x_rs_e, x_rt_e;
    logic       x_rt_m;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  // ---------------------------------------------------------------------------
  // Reference model: spec rules written with per-stage arrays
  // ---------------------------------------------------------------------------
  int m_busy_left;
  bit m_in_exc;

  function automatic bit writes(input logic [2:0] r);
    return (r >= 1) && (r <= 4);
  endfunction

  function automatic int tnew_of(input int stage, input logic [2:0] r);
    int te [8] = '{0, 1, 2, 0, 1, 0, 0, 0};
    if (stage == 0) return te[r];
    if (stage == 1) return (r == 2) ? 1 : 0;
    return 0;
  endfunction

  function automatic logic [14:0] model();
    logic [4:0] was  [3] = '{wa_E, wa_M, wa_W};
    logic [2:0] ress [3] = '{Res_E, Res_M, Res_W};
    logic [4:0] srcs [2] = '{rs_D, rt_D};
    int         tus  [2] = '{int'(tuse_rs_D), int'(tuse_rt_D)};
    logic [4:0] esrc [2] = '{rs_E, rt_E};
    int  fd [2];
    int  fe [2];
    int  fm;
    bit  stall, busy;
    busy  = (m_busy_left > 0);
    stall = md_use_D && (md_start_E || busy);
    for (int o = 0; o < 2; o++) begin
      fd[o] = 0;
      fe[o] = 0;
      for (int s = 0; s < 2; s++)
        if (tus[o] != 3 && writes(ress[s]) && was[s] != 0 && was[s] == srcs[o]
            && tnew_of(s, ress[s]) > tus[o])
          stall = 1;
      for (int s = 2; s >= 0; s--)
        if (writes(ress[s]) && was[s] != 0 && was[s] == srcs[o]
            && tnew_of(s, ress[s]) == 0)
          fd[o] = s + 1;
      for (int s = 2; s >= 1; s--)
        if (writes(ress[s]) && was[s] != 0 && was[s] == esrc[o]
            && tnew_of(s, ress[s]) == 0)
          fe[o] = s + 1;
    end
    fm = (writes(Res_W) && wa_W != 0 && wa_W == rt_M) ? 1 : 0;
    if (exc_req)
      return pack(1, 1, 1, 1, 1, busy, 2'(fd[0]), 2'(fd[1]), 2'(fe[0]),
                  2'(fe[1]), fm[0]);
    return pack(!stall, !stall, m_in_exc, stall, 0, busy, 2'(fd[0]), 2'(fd[1]),
                2'(fe[0]), 2'(fe[1]), fm[0]);
  endfunction

  task automatic model_edge();
    if (md_start_E && !exc_req) m_busy_left = md_div_E ? 10 : 5;
    else if (m_busy_left > 0)   m_busy_left--;
    m_in_exc = exc_req;
  endtask

  task automatic do_reset();
    @(negedge clk);
    neutral();
    reset = 1'b0;
    #1;
    check("reset_outputs", act, IDLE);
    @(negedge clk);
    reset = 1'b1;
    m_busy_left = 0;
    m_in_exc = 0;
  endtask

  initial begin
    //          name              rsD rtD tr tt waE rE waM rM waW rW rsE rtE rtM st fD fT fE fR fM
    tbl[0]  = '{"neutral",         0,  0, 3, 3, 0, 0,  0, 0,  0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{"alu_m_fwd_e",     0,  0, 3, 3, 0, 0,  3, 1,  0, 0,  3,  0,  0, 0, 0, 0, 2, 0, 0};
    tbl[2]  = '{"alu_m_wa0",       0,  0, 3, 3, 0, 0,  0, 1,  0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{"jal_jr",         31,  0, 0, 3, 31, 3, 0, 0,  0, 0,  0,  0,  0, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{"alu_e_tuse0",     5,  0, 0, 3, 5, 1,  0, 0,  0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{"alu_e_tuse1",     5,  0, 1, 3, 5, 1,  0, 0,  0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{"dm_e_tuse1",      0,  5, 3, 1, 5, 2,  0, 0,  0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0};
    tbl[7]  = '{"dm_m_tuse1",      0,  5, 3, 1, 0, 0,  5, 2,  0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{"dm_m_tuse0",      0,  5, 3, 0, 0, 0,  5, 2,  0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0};
    tbl[9]  = '{"dm_e_unused",     5,  0, 3, 3, 5, 2,  0, 0,  0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{"md_e_tuse0",      7,  0, 0, 3, 7, 4,  0, 0,  0, 0,  0,  0,  0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{"res5_nw",         7,  0, 0, 3, 7, 5,  0, 0,  0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{"m_over_w",        9,  0, 0, 3, 0, 0,  9, 1,  9, 2,  0,  9,  0, 0, 2, 0, 0, 2, 0};
    tbl[13] = '{"w_fwd",           0,  4, 3, 2, 0, 0,  0, 0,  4, 4,  4,  0,  4, 0, 0, 3, 3, 0, 1};
    tbl[14] = '{"zero_reg",        0,  0, 0, 0, 0, 2,  0, 0,  0, 1,  0,  0,  0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{"pc_in_m",        31,  0, 0, 3, 0, 0, 31, 3,  0, 0,  0,  0,  0, 0, 2, 0, 0, 0, 0};
    tbl[16] = '{"alu_e_skip_to_w", 6,  0, 2, 3, 6, 1,  0, 0,  6, 1,  0,  0,  0, 0, 3, 0, 0, 0, 0};
    tbl[17] = '{"nw_in_w",         0,  0, 3, 3, 0, 0,  0, 0,  4, 0,  0,  0,  4, 0, 0, 0, 0, 0, 0};

    neutral();
    #2 reset = 1'b0;
    #1 check("reset_outputs", act, IDLE);
    @(negedge clk);
    reset = 1'b1;
    m_busy_left = 0;
    m_in_exc = 0;

    // ---- table vectors ----
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      neutral();
      rs_D = tbl[i].rs_d; rt_D = tbl[i].rt_d;
      tuse_rs_D = tbl[i].tu_rs; tuse_rt_D = tbl[i].tu_rt;
      wa_E = tbl[i].wa_e; Res_E = tbl[i].res_e;
      wa_M = tbl[i].wa_m; Res_M = tbl[i].res_m;
      wa_W = tbl[i].wa_w; Res_W = tbl[i].res_w;
      rs_E = tbl[i].rs_e; rt_E = tbl[i].rt_e; rt_M = tbl[i].rt_m;
      #1;
      check(tbl[i].name, act,
            pack(!tbl[i].x_stall, !tbl[i].x_stall, 0, tbl[i].x_stall, 0, 0,
                 tbl[i].x_rs_d, tbl[i].x_rt_d, tbl[i].x_rs_e, tbl[i].x_rt_e,
                 tbl[i].x_rt_m));
    end

    // ---- load-use: lw r8 followed by beq on r8 (tuse 0) ----
    @(negedge clk);
    neutral(); rs_D = 8; tuse_rs_D = 0; Res_E = 2; wa_E = 8;
    #1 check("loaduse_c1", act, STALL);
    @(negedge clk);
    neutral(); rs_D = 8; tuse_rs_D = 0; Res_M = 2; wa_M = 8;
    #1 check("loaduse_c2", act, STALL);
    @(negedge clk);
    neutral(); rs_D = 8; tuse_rs_D = 0; Res_W = 2; wa_W = 8;
    #1 check("loaduse_c3_fwd_w", act, pack(1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));

    // ---- div then mflo: stall through start cycle plus 10 busy cycles ----
    @(negedge clk);
    neutral(); md_use_D = 1; md_start_E = 1; md_div_E = 1;
    #1 check("div_start", act, STALL);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      neutral(); md_use_D = 1;
      #1 check($sformatf("div_busy_%0d", k), act,
               pack(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    neutral(); md_use_D = 1;
    #1 check("div_done", act, IDLE);

    // ---- exception overrides stall and suppresses an MD start ----
    @(negedge clk);
    neutral(); rs_D = 8; tuse_rs_D = 0; Res_E = 2; wa_E = 8;
    md_use_D = 1; md_start_E = 1; exc_req = 1;
    #1 check("exc_override", act, 15'b111110_00_00_00_00_0);
    @(negedge clk);
    neutral();
    #1 check("exc_slot", act, 15'b111000_00_00_00_00_0);
    @(negedge clk);
    neutral();
    #1 check("exc_back_to_run", act, IDLE);

    // ---- reset asserted while a multiply is counting ----
    @(negedge clk);
    neutral(); md_start_E = 1;
    @(negedge clk);
    neutral();
    @(negedge clk);
    #1 check("mult_count_3", act, pack(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1 check("reset_mid_count", act, IDLE);
    @(negedge clk);
    reset = 1'b1;
    m_busy_left = 0;
    m_in_exc = 0;

    // ---- randomized run against the reference model ----
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      tuse_rs_D = 2'($urandom_range(0, 3)); tuse_rt_D = 2'($urandom_range(0, 3));
      wa_E = 5'($urandom_range(0, 3)); wa_M = 5'($urandom_range(0, 3));
      wa_W = 5'($urandom_range(0, 3));
      Res_E = 3'($urandom_range(0, 7)); Res_M = 3'($urandom_range(0, 7));
      Res_W = 3'($urandom_range(0, 7));
      rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
      rt_M = 5'($urandom_range(0, 3));
      md_use_D   = ($urandom_range(0, 3) == 0);
      md_start_E = ($urandom_range(0, 7) == 0);
      md_div_E   = $urandom_range(0, 1) != 0;
      exc_req    = ($urandom_range(0, 15) == 0);
      #1 check("random", act, model());
      @(posedge clk);
      model_edge();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/forward/flush controller for the five-stage MIPS pipeline. Compares decode-stage source registers against the register-write class (Res) and write address carried by the E, M and W pipeline registers, and generates PC/IF-ID enables, bubble/flush controls for the ID-EX, EX-MEM and IF-ID registers, and all forwarding mux selects. Owns the multiply/divide busy counter and exception-flush sequencing, so pipeline registers hold no hazard logic.

## Interface
- MULT_CYC, 5: busy cycles after a mult/multu start
- DIV_CYC, 10: busy cycles after a div/divu start
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rs_D, rt_D  in  5 each  decode-stage source registers
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until the D instruction needs the operand (0/1/2); 3 = operand unused
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- wa_E, wa_M, wa_W  in  5 each  destination register per stage
- Res_E, Res_M, Res_W  in  3 each  result class: 0 NW (no write), 1 ALU, 2 DM (load), 3 PC (link), 4 MD (mfhi/mflo); 5-7 treated as NW
- rs_E, rt_E, rt_M  in  5 each  operand registers in later stages
- md_start_E  in  1  mult/div issuing from E this cycle
- md_div_E  in  1  1 = divide, 0 = multiply (valid with md_start_E)
- exc_req  in  1  CP0 exception/interrupt taken at M
- en_PC, en_D  out  1 each  PC and IF-ID write enables
- flush_D, flush_E, flush_M  out  1 each  synchronous clear of IF-ID, ID-EX, EX-MEM on the next edge
- md_busy  out  1  mult/div unit busy
- fwd_rs_D, fwd_rt_D  out  2 each  0 regfile, 1 E, 2 M, 3 W
- fwd_rs_E, fwd_rt_E  out  2 each  0 pipeline value, 2 M, 3 W
- fwd_rt_M  out  1  0 pipeline value, 1 W

## Operation
- Tnew by stage: E: ALU 1, DM 2, PC 0, MD 1; M: DM 1, other writing classes 0; W: 0. NW or wa = 0 never matches.
- Data stall: for each of rs_D/rt_D with tuse != 3, any E or M entry with matching nonzero wa, writing class and Tnew > tuse.
- MD stall: md_use_D & (md_start_E | md_busy).
- stall = data stall | MD stall. On stall: en_PC = 0, en_D = 0, flush_E = 1 (bubble); flush_D = flush_M = 0.
- Forwarding (nearest stage wins, only from stages with Tnew = 0, matching writing class, wa != 0): D from E (PC class only), then M, then W; E from M, then W; M rt from W. Otherwise select 0.
- Busy counter (4 bits, saturating sizing: max(MULT_CYC, DIV_CYC)): on md_start_E & !exc_req load MULT_CYC or DIV_CYC; else decrement when nonzero. md_busy = (count != 0).
- Exception: exc_req overrides stall: en_PC = 1, en_D = 1, flush_D = flush_E = flush_M = 1. md_start_E in the same cycle is suppressed (no load); an operation already counting continues to completion.
- FSM: RUN, EXC. RUN -> EXC on exc_req. EXC holds flush_D only (handler fetch slot; delay-slot instruction discarded) for one cycle, then -> RUN; exc_req in EXC re-enters EXC. Stall evaluation applies in EXC as in RUN.
- All stall/forward/flush outputs combinational from inputs, count and state; only count and state are registered.

## Timing
- Reset (reset = 0, asynchronous): state RUN, count 0, md_busy 0; with neutral inputs en_PC = en_D = 1, flushes 0, fwd selects 0.
- Stall visible same cycle as the hazardous inputs; bubble enters E on the next edge.
- Load-use (DM in E, tuse 0): 2 stall cycles; DM in E, tuse 1: 1 cycle.
- md_busy rises the edge after md_start_E, stays high exactly MULT_CYC/DIV_CYC cycles.
- Reset asserted mid-count clears count immediately.

## Test plan
- Load r8 in E (Res_E = 2, wa_E = 8), beq in D with rs_D = 8, tuse 0 -> stall 2 cycles, then fwd_rs_D = 2 (from M) is not used; fwd_rs_D = 3 (from W) after second cycle.
- addu r3 in M (Res_M = 1, wa_M = 3), rs_E = 3 -> fwd_rs_E = 2, no stall; wa_M = 0 instead -> fwd_rs_E = 0.
- jal in E (Res_E = 3, wa_E = 31), jr rs_D = 31 tuse 0 -> fwd_rs_D = 1, no stall.
- div start (md_div_E = 1) then mflo in D -> md_busy high 10 cycles, stall through start cycle plus 10 busy cycles, released when count reaches 0.
- exc_req with data stall and md_start_E active -> en_PC = 1, flush_D/E/M = 1, count stays 0; next cycle state EXC flush_D = 1 only.
- reset low during MULT busy count 3 -> md_busy 0 immediately, outputs at reset values.
